rowbuff_ctrl: RTL and testbench

Sequencer that fills one matrix in the row buffer from a row-addressed source memory. It fetches ROW_COUNT consecutive rows starting at a base address, and strobes each returned row into the buffer. It then issues the end-of-data flush, waits for the buffer's set flag, and holds a matrix-ready handshake until the downstream matrix engine accepts it. It sits between the row memory, the row buffer and the matrix compute stage.

---
 rtl/rowbuff_pkg.sv | 20 ++
 rtl/rowbuff_if.sv | 36 +++
 rtl/rowbuff_ctrl.sv | 98 +++++++++
 tb/tb_rowbuff_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rowbuff_pkg.sv
// Shared types and constants for the row buffer fill sequencer.
package rowbuff_pkg;

  localparam int MAT_COUNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FLUSH,
    S_SETTLE,
    S_DONE
  } state_e;

  // Row index width: clog2 of the row count, never narrower than one bit.
  function automatic int row_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rowbuff_if.sv
// Control, row memory, row buffer and matrix handshake bundle.
interface rowbuff_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int ROW_IDX_W  = 3
);
  import rowbuff_pkg::*;

  logic                   start;
  logic                   abort;
  logic [ADDR_WIDTH-1:0]  baseAddr;
  logic                   memReq;
  logic [ADDR_WIDTH-1:0]  memAddr;
  logic                   memAck;
  logic                   memValid;
  logic                   buffEnable;
  logic                   buffDend;
  logic                   buffSet;
  logic                   matValid;
  logic                   matAck;
  logic                   busy;
  logic [ROW_IDX_W-1:0]   rowIdx;
  logic [MAT_COUNT_W-1:0] matCount;

  // Sequencer side.
  modport slave (
    input  start, abort, baseAddr, memAck, memValid, buffSet, matAck,
    output memReq, memAddr, buffEnable, buffDend, matValid, busy, rowIdx, matCount
  );

  // Environment side: memory, buffer, consumer and controlling host.
  modport master (
    output start, abort, baseAddr, memAck, memValid, buffSet, matAck,
    input  memReq, memAddr, buffEnable, buffDend, matValid, busy, rowIdx, matCount
  );

endinterface

// File: rtl/rowbuff_ctrl.sv
// Fills one matrix in the row buffer: fetch ROW_COUNT rows, flush, wait for
// the buffer set flag, then hand the matrix to the compute stage.
module rowbuff_ctrl
  import rowbuff_pkg::*;
#(
  parameter int ROW_COUNT  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int ROW_IDX_W  = row_idx_w(ROW_COUNT)
) (
  input logic       clock,
  input logic       reset,
  rowbuff_if.slave  bus
);

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROW_COUNT - 1);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [ROW_IDX_W-1:0]   row_q, row_d;
  logic [MAT_COUNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   req_q, dend_q, mval_q, busy_q;

  // Next-state, row counter, base latch and completion counter.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    if (bus.abort) begin
      state_d = S_IDLE;
      row_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          base_d  = bus.baseAddr;
          row_d   = '0;
          state_d = S_REQ;
        end
        S_REQ:  if (bus.memAck) state_d = S_WAIT;
        S_WAIT: if (bus.memValid) begin
          if (row_q == LAST_ROW) state_d = S_FLUSH;
          else begin
            row_d   = row_q + 1'b1;
            state_d = S_REQ;
          end
        end
        S_FLUSH:  state_d = S_SETTLE;
        S_SETTLE: if (bus.buffSet) state_d = S_DONE;
        S_DONE:   if (bus.matAck) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_IDLE;
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // State plus registered outputs, decoded from the state being entered so
  // they line up with the state register without a decode glitch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      dend_q  <= 1'b0;
      mval_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      // Address wraps modulo 2^ADDR_WIDTH; only refreshed when (re)entering REQ.
      if (state_d == S_REQ) addr_q <= base_d + ADDR_WIDTH'(row_d);
      req_q   <= (state_d == S_REQ);
      dend_q  <= (state_d == S_FLUSH);
      mval_q  <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Buffer strobe is combinational so the row is captured in its valid cycle;
  // abort masks both buffer controls in the abort cycle.
  assign bus.buffEnable = !bus.abort &&
                          ((state_q == S_FLUSH) || ((state_q == S_WAIT) && bus.memValid));
  assign bus.buffDend   = dend_q && !bus.abort;
  assign bus.memReq     = req_q;
  assign bus.memAddr    = addr_q;
  assign bus.matValid   = mval_q;
  assign bus.busy       = busy_q;
  assign bus.rowIdx     = row_q;
  assign bus.matCount   = cnt_q;

endmodule

// File: tb/tb_rowbuff_ctrl.sv
// Scoreboard bench for rowbuff_ctrl: stimulus pushes the expected event
// stream, a negedge monitor pops and compares as the DUT produces events.
module tb_rowbuff_ctrl;
  import rowbuff_pkg::*;

  localparam int RC  = 8;
  localparam int AW  = 8;
  localparam int RIW = 3;

  localparam int EV_ADDR  = 0;
  localparam int EV_ROW   = 1;
  localparam int EV_FLUSH = 2;
  localparam int EV_MAT   = 3;

  typedef struct {
    int kind;
    int data;
  } ev_t;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   fails;
  int   model_cnt;
  int   dend_cyc;
  int   mv_cyc;
  ev_t  exp_q[$];

  logic          prev_req, prev_ack, prev_mv;
  logic [AW-1:0] prev_addr;

  rowbuff_if #(.ADDR_WIDTH(AW), .ROW_IDX_W(RIW)) bus ();

  rowbuff_ctrl #(.ROW_COUNT(RC), .ADDR_WIDTH(AW), .ROW_IDX_W(RIW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic pop_chk(input string nm, input int kind, input int data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s: unexpected event kind %0d data %0d, nothing expected (cycle %0d)",
               nm, kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_kind"}, kind, e.kind);
      chk({nm, "_data"}, data, e.data);
    end
  endtask

  // Monitor: compare every DUT event against the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      if (bus.memReq && bus.memAck) pop_chk("mem_addr", EV_ADDR, int'(bus.memAddr));
      if (bus.buffEnable && !bus.buffDend) begin
        pop_chk("row_strobe", EV_ROW, int'(bus.rowIdx));
        chk("enable_needs_valid", int'(bus.memValid), 1);
      end
      if (bus.buffDend) begin
        pop_chk("flush", EV_FLUSH, 0);
        chk("flush_enable", int'(bus.buffEnable), 1);
        dend_cyc = cyc;
      end
      if (bus.matValid && bus.matAck) pop_chk("mat_accept", EV_MAT, int'(bus.matCount));
      if (bus.matValid && !prev_mv) mv_cyc = cyc;
      if (prev_req && !prev_ack && bus.memReq) chk("req_addr_hold", int'(bus.memAddr), int'(prev_addr));
    end
    prev_req  = reset && bus.memReq;
    prev_ack  = bus.memAck;
    prev_addr = bus.memAddr;
    prev_mv   = reset && bus.matValid;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One matrix load. abort_row < 0 means no abort; otherwise abort lands in
  // that row's memValid cycle.
  task automatic do_load(input int base, input int ackd, input int vald, input int settle,
                         input int ackwait, input int abort_row, input bit start_in_done);
    int t0;
    for (int r = 0; r < RC; r++) begin
      exp_q.push_back(ev_t'{EV_ADDR, (base + r) % 256});
      if (r == abort_row) break;
      exp_q.push_back(ev_t'{EV_ROW, r});
    end
    if (abort_row < 0) begin
      exp_q.push_back(ev_t'{EV_FLUSH, 0});
      exp_q.push_back(ev_t'{EV_MAT, model_cnt});
    end

    bus.baseAddr = AW'(base);
    bus.start    = 1'b1;
    t0 = cyc;
    step();
    bus.start    = 1'b0;
    bus.baseAddr = AW'($urandom);
    for (int r = 0; r < RC; r++) begin
      repeat (ackd) step();
      bus.memAck = 1'b1;
      step();
      bus.memAck = 1'b0;
      repeat (vald - 1) step();
      bus.memValid = 1'b1;
      if (r == abort_row) begin
        bus.abort = 1'b1;
        #1 chk("abort_no_enable", int'(bus.buffEnable), 0);
      end
      step();
      bus.memValid = 1'b0;
      if (r == abort_row) begin
        bus.abort = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_rowidx", int'(bus.rowIdx), 0);
        chk("abort_matcount", int'(bus.matCount), model_cnt);
        return;
      end
    end
    step();
    repeat (settle) step();
    bus.buffSet = 1'b1;
    step();
    bus.buffSet = 1'b0;
    for (int i = 0; i < ackwait; i++) begin
      chk("matvalid_hold", int'(bus.matValid), 1);
      if (start_in_done && i == 0) bus.start = 1'b1;
      step();
      bus.start = 1'b0;
    end
    bus.matAck = 1'b1;
    step();
    bus.matAck = 1'b0;
    model_cnt = (model_cnt + 1) % 256;
    chk("dend_cycle", dend_cyc - t0, 1 + RC * (ackd + 1 + vald));
    chk("matvalid_cycle", mv_cyc - dend_cyc, 2 + settle);
    chk("matcount", int'(bus.matCount), model_cnt);
    chk("idle_after_ack", int'(bus.busy), 0);
    step();
    chk("start_not_queued", int'(bus.busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_memReq"},     int'(bus.memReq), 0);
    chk({tag, "_memAddr"},    int'(bus.memAddr), 0);
    chk({tag, "_buffEnable"}, int'(bus.buffEnable), 0);
    chk({tag, "_buffDend"},   int'(bus.buffDend), 0);
    chk({tag, "_matValid"},   int'(bus.matValid), 0);
    chk({tag, "_busy"},       int'(bus.busy), 0);
    chk({tag, "_rowIdx"},     int'(bus.rowIdx), 0);
    chk({tag, "_matCount"},   int'(bus.matCount), 0);
  endtask

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    cyc = 0; checks = 0; fails = 0; model_cnt = 0; dend_cyc = 0; mv_cyc = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.baseAddr = '0;
    bus.memAck = 1'b0; bus.memValid = 1'b0; bus.buffSet = 1'b0; bus.matAck = 1'b0;
    repeat (3) @(posedge clock);
    #1 chk_all_zero("reset");
    #2 reset = 1'b1;
    step();

    do_load(8'h10, 0, 1, 0, 0, -1, 1'b0);   // nominal, zero-wait
    do_load(8'hFE, 0, 1, 0, 1, -1, 1'b0);   // address wrap
    do_load(8'h40, 3, 2, 0, 0, -1, 1'b0);   // stalled memory
    do_load(8'h20, 0, 1, 0, 0, 3, 1'b0);    // abort at row 3 valid
    do_load(8'h20, 0, 1, 0, 0, -1, 1'b0);   // clean restart
    do_load(8'h80, 1, 1, 1, 10, -1, 1'b1);  // backpressure + ignored start

    for (int n = 0; n < 8; n++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, RC - 1)) : -1;
      do_load(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 4)), ab, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset landing mid-WAIT with memValid high.
    exp_q.push_back(ev_t'{EV_ADDR, 8'h33});
    bus.baseAddr = 8'h33;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.memAck = 1'b1;
    step();
    bus.memAck = 1'b0;
    bus.memValid = 1'b1;
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    exp_q.delete();
    model_cnt = 0;
    bus.memValid = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    step();

    do_load(8'h05, 0, 1, 0, 0, -1, 1'b0);   // runs cleanly after reset

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
